// File: rtl/bch80_64_enc.sv
// Iterative (80,64) BCH/Hamming encoder: B data bits per cycle,
// check-matrix columns generated on the fly by an LFSR-style step.
module bch80_64_enc #(
   parameter int B = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [79:0] out_code,
   output logic [15:0] out_parity
);

   localparam int STEPS = 64 / B;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CW-1:0] LAST = CW'(STEPS - 1);
   localparam logic [15:0] COL0 = 16'h6097;
   localparam logic [15:0] POLY = 16'hC6F6;

   if (!(B == 1 || B == 2 || B == 4 || B == 8 ||
         B == 16 || B == 32 || B == 64)) begin : g_bad_b
      $fatal(1, "bch80_64_enc: B must be a power of two in 1..64");
   end

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t state, state_nxt;

   logic [63:0]   shreg;
   logic [63:0]   hold;
   logic [15:0]   acc, acc_nxt;
   logic [15:0]   col, col_nxt;
   logic [CW-1:0] cnt;
   logic          accept;
   logic          last;

   function automatic logic [15:0] colstep(input logic [15:0] c);
      return (c >> 1) ^ (c[0] ? POLY : 16'h0000);
   endfunction

   assign in_ready   = (state == IDLE) & ~rst;
   assign accept     = in_valid & in_ready;
   assign last       = (cnt == LAST);
   assign out_valid  = (state == DONE);
   assign out_code   = {hold, acc};
   assign out_parity = acc;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (accept)    state_nxt = BUSY;
         BUSY: if (last)      state_nxt = DONE;
         DONE: if (out_ready) state_nxt = IDLE;
         default:             state_nxt = IDLE;
      endcase
   end

   // Unrolled B-step chain: accumulate, then advance the column.
   always_comb begin
      acc_nxt = acc;
      col_nxt = col;
      for (int k = 0; k < B; k++) begin
         if (shreg[63-k]) acc_nxt = acc_nxt ^ col_nxt;
         col_nxt = colstep(col_nxt);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg <= '0;
         hold  <= '0;
         acc   <= '0;
         col   <= '0;
         cnt   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  shreg <= in_data;
                  hold  <= in_data;
                  acc   <= '0;
                  col   <= COL0;
                  cnt   <= '0;
               end
            end
            BUSY: begin
               shreg <= shreg << B;
               acc   <= acc_nxt;
               col   <= col_nxt;
               cnt   <= cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bch80_64_enc.sv
// Directed and closed-loop checks of bch80_64_enc at B = 1, 8 and 64.
module tb_bch80_64_enc;

   logic        clk = 1'b0;
   logic        rst       [3];
   logic        in_valid  [3];
   logic        in_ready  [3];
   logic [63:0] in_data   [3];
   logic        out_valid [3];
   logic        out_ready [3];
   logic [79:0] out_code  [3];
   logic [15:0] out_parity[3];

   int errors = 0;
   int checks = 0;
   int steps[3] = '{64, 8, 1};

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      bch80_64_enc #(.B((g == 0) ? 1 : (g == 1) ? 8 : 64)) dut (
         .clk       (clk),
         .rst       (rst[g]),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .in_data   (in_data[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .out_code  (out_code[g]),
         .out_parity(out_parity[g])
      );
   end

   function automatic logic [15:0] colj(input int j);
      logic [15:0] c;
      c = 16'h6097;
      for (int i = 0; i < j; i++)
         c = (c >> 1) ^ (c[0] ? 16'hC6F6 : 16'h0000);
      return c;
   endfunction

   // Independent checker: syndrome over all 80 codeword bits.
   function automatic logic [15:0] syndrome(input logic [79:0] cw);
      logic [15:0] s;
      s = cw[15:0];
      for (int i = 16; i < 80; i++)
         if (cw[i]) s = s ^ colj(79 - i);
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one word through both handshakes; no checking here.
   task automatic run_word(input int d, input logic [63:0] data,
                           output logic [79:0] code,
                           output logic [15:0] par,
                           output int lat, output bit to);
      int n;
      n = 0;
      while (!in_ready[d] && n < 300) begin
         tick();
         n++;
      end
      in_valid[d] = 1'b1;
      in_data[d]  = data;
      tick();
      in_valid[d] = 1'b0;
      in_data[d]  = ~data;
      lat = 0;
      while (!out_valid[d] && lat < 300) begin
         tick();
         lat++;
      end
      to   = !out_valid[d];
      code = out_code[d];
      par  = out_parity[d];
      out_ready[d] = 1'b1;
      tick();
      out_ready[d] = 1'b0;
   endtask

   task automatic test_reset(input int d);
      bit bad;
      rst[d]      = 1'b1;
      in_valid[d] = 1'b1;
      in_data[d]  = 64'h8000_0000_0000_0000;
      bad = 1'b0;
      repeat (3) begin
         tick();
         if (in_ready[d] !== 1'b0 || out_valid[d] !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL reset_hold d=%0d: ready/valid not 0 in reset", d);
      end
      checks++;
      if (out_code[d] !== 80'h0) begin
         errors++;
         $display("FAIL reset_code d=%0d: got %h want 0", d, out_code[d]);
      end
      rst[d]      = 1'b0;
      in_valid[d] = 1'b0;
      #1;
      checks++;
      if (in_ready[d] !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready d=%0d: got %b want 1", d, in_ready[d]);
      end
      bad = 1'b0;
      repeat (steps[d] + 4) begin
         tick();
         if (out_valid[d] !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL reset_noaccept d=%0d: out_valid rose, want 0", d);
      end
   endtask

   task automatic test_single_bits(input int d);
      logic [63:0] vd[7];
      logic [15:0] vp[7];
      logic [79:0] code;
      logic [15:0] par;
      int lat;
      bit to;
      vd = '{64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000,
             64'h0000_0000_0000_0001, 64'h0,
             64'hC000_0000_0000_0000, 64'h2000_0000_0000_0000,
             64'h0002_0000_0000_0000};
      vp = '{16'h6097, 16'hF6BD, 16'h8DED, 16'h0000,
             16'h962A, 16'hBDA8, 16'hE500};
      for (int v = 0; v < 7; v++) begin
         run_word(d, vd[v], code, par, lat, to);
         checks++;
         if (to || lat != steps[d]) begin
            errors++;
            $display("FAIL latency d=%0d v=%0d: got %0d want %0d",
                     d, v, lat, steps[d]);
         end
         checks++;
         if (code !== {vd[v], vp[v]}) begin
            errors++;
            $display("FAIL code d=%0d v=%0d: got %h want %h",
                     d, v, code, {vd[v], vp[v]});
         end
         checks++;
         if (par !== vp[v]) begin
            errors++;
            $display("FAIL parity d=%0d v=%0d: got %h want %h",
                     d, v, par, vp[v]);
         end
         checks++;
         if (out_valid[d] !== 1'b0) begin
            errors++;
            $display("FAIL valid_drop d=%0d v=%0d: got %b want 0",
                     d, v, out_valid[d]);
         end
      end
   endtask

   task automatic test_backpressure(input int d);
      logic [63:0] wa, wb;
      logic [79:0] code0;
      bit stable, rdy_seen;
      int lat;
      wa = 64'h4000_0000_0000_0000;
      wb = 64'h0000_0000_0000_0001;
      in_valid[d] = 1'b1;
      in_data[d]  = wa;
      tick();
      in_data[d] = wb;
      lat = 0;
      while (!out_valid[d] && lat < 300) begin
         tick();
         lat++;
      end
      code0 = out_code[d];
      checks++;
      if (code0 !== {wa, 16'hF6BD}) begin
         errors++;
         $display("FAIL bp_first d=%0d: got %h want %h",
                  d, code0, {wa, 16'hF6BD});
      end
      stable   = 1'b1;
      rdy_seen = 1'b0;
      repeat (20) begin
         tick();
         if (out_code[d] !== code0 || out_valid[d] !== 1'b1) stable = 1'b0;
         if (in_ready[d] !== 1'b0) rdy_seen = 1'b1;
      end
      checks++;
      if (!stable) begin
         errors++;
         $display("FAIL bp_stable d=%0d: output moved, want held", d);
      end
      checks++;
      if (rdy_seen) begin
         errors++;
         $display("FAIL bp_ready d=%0d: in_ready 1, want 0", d);
      end
      out_ready[d] = 1'b1;
      tick();
      out_ready[d] = 1'b0;
      checks++;
      if (in_ready[d] !== 1'b1) begin
         errors++;
         $display("FAIL bp_idle d=%0d: in_ready %b want 1", d, in_ready[d]);
      end
      tick();
      in_valid[d] = 1'b0;
      in_data[d]  = 64'hFFFF_FFFF_FFFF_FFFF;
      lat = 0;
      while (!out_valid[d] && lat < 300) begin
         tick();
         lat++;
      end
      checks++;
      if (lat != steps[d] || out_code[d] !== {wb, 16'h8DED}) begin
         errors++;
         $display("FAIL bp_second d=%0d: got %h lat %0d want %h lat %0d",
                  d, out_code[d], lat, {wb, 16'h8DED}, steps[d]);
      end
      out_ready[d] = 1'b1;
      tick();
      out_ready[d] = 1'b0;
   endtask

   task automatic test_mid_reset();
      logic [79:0] code;
      logic [15:0] par;
      int lat;
      bit to, pulse;
      in_valid[1] = 1'b1;
      in_data[1]  = 64'hDEAD_BEEF_0123_4567;
      tick();
      in_valid[1] = 1'b0;
      repeat (3) tick();
      rst[1] = 1'b1;
      tick();
      rst[1] = 1'b0;
      #1;
      checks++;
      if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1 ||
          out_code[1] !== 80'h0) begin
         errors++;
         $display("FAIL midrst_state: valid %b ready %b code %h want 0 1 0",
                  out_valid[1], in_ready[1], out_code[1]);
      end
      pulse = 1'b0;
      repeat (20) begin
         tick();
         if (out_valid[1] !== 1'b0) pulse = 1'b1;
      end
      checks++;
      if (pulse) begin
         errors++;
         $display("FAIL midrst_pulse: out_valid rose, want 0");
      end
      run_word(1, 64'hC000_0000_0000_0000, code, par, lat, to);
      checks++;
      if (to || lat != 8 || code !== {64'hC000_0000_0000_0000, 16'h962A}) begin
         errors++;
         $display("FAIL midrst_next: got %h lat %0d want %h lat 8",
                  code, lat, {64'hC000_0000_0000_0000, 16'h962A});
      end
   endtask

   task automatic test_closed_loop(input int d, input int n);
      logic [63:0] data;
      logic [79:0] code;
      logic [15:0] par, s, want;
      int lat, bi;
      bit to;
      for (int k = 0; k < n; k++) begin
         data = {$urandom, $urandom};
         run_word(d, data, code, par, lat, to);
         checks++;
         if (to || code[79:16] !== data || syndrome(code) !== 16'h0) begin
            errors++;
            $display("FAIL loop_syn d=%0d k=%0d: code %h syn %h want syn 0",
                     d, k, code, syndrome(code));
         end
         bi   = int'($urandom_range(79, 0));
         s    = syndrome(code ^ (80'h1 << bi));
         want = (bi >= 16) ? colj(79 - bi) : (16'h1 << bi);
         checks++;
         if (s !== want) begin
            errors++;
            $display("FAIL loop_flip d=%0d bit=%0d: got %h want %h",
                     d, bi, s, want);
         end
      end
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         rst[d]       = 1'b1;
         in_valid[d]  = 1'b0;
         in_data[d]   = '0;
         out_ready[d] = 1'b0;
      end
      for (int d = 0; d < 3; d++) test_reset(d);
      for (int d = 0; d < 3; d++) test_single_bits(d);
      for (int d = 0; d < 3; d++) test_backpressure(d);
      test_mid_reset();
      test_closed_loop(0, 60);
      test_closed_loop(1, 300);
      test_closed_loop(2, 300);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
